linebuffer_sched: RTL and testbench

- Draw-domain sequencer for the dual line-buffer datapath.
- On each line-start pulse it flips `buffsel_draw`, then sweeps a clear of the newly on-screen line 8 pixels per cycle.
- In parallel it round-robin arbitrates two drawing requesters (e.g. tile and sprite engines) onto the single off-screen 8-pixel write port.
- Sits between the rasterisers and the line-buffer pair. The pix-domain flip is owned elsewhere.

---
 rtl/linebuffer_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/linebuffer_sched.sv | 104 ++++++++++
 tb/tb_linebuffer_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// Shared types for the dual line-buffer draw-side datapath.
package linebuffer_pkg;
    localparam int PIX_PER_WORD = 8;
    localparam int COLOUR_W     = 9;

    typedef logic [COLOUR_W-1:0]              colour_t;
    typedef logic [PIX_PER_WORD*COLOUR_W-1:0] lb_word_t;
    typedef logic [8:0]                       lb_addr_t;
    typedef logic [PIX_PER_WORD-1:0]          lb_we_t;

    typedef enum logic {IDLE, ACTIVE} sched_state_t;

    typedef struct packed {
        lb_addr_t addr;
        lb_we_t   we;
        lb_word_t colour;
    } lb_wr_t;

    function automatic lb_word_t replicate(colour_t c);
        return {PIX_PER_WORD{c}};
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);
    // Index of the requester granted most recently; reset to 1 so req0 wins the first tie.
    logic last;

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (en && (|grant))
            last <= grant[1];
    end
endmodule

// File: rtl/linebuffer_sched.sv
// Draw-domain sequencer: flips the buffer select on each line start, sweeps a clear
// of the on-screen line and arbitrates two rasterisers onto the off-screen port.
module linebuffer_sched
    import linebuffer_pkg::*;
#(
    parameter int      LINE_WORDS   = 80,
    parameter colour_t CLEAR_COLOUR = 9'h000
) (
    input  logic     clk_draw,
    input  logic     rst_draw,
    input  logic     line_start,
    output logic     buffsel_draw,
    output lb_addr_t addr_on_draw,
    output logic     we_on_draw,
    output lb_word_t colour_on_draw,
    output lb_addr_t addr_off_draw,
    output lb_we_t   we_off_draw,
    output lb_word_t colour_off_draw,
    input  logic     req0_valid,
    input  lb_addr_t req0_addr,
    input  lb_we_t   req0_we,
    input  lb_word_t req0_colour,
    input  logic     req1_valid,
    input  lb_addr_t req1_addr,
    input  lb_we_t   req1_we,
    input  lb_word_t req1_colour,
    output logic     req0_ready,
    output logic     req1_ready,
    output logic     clear_busy,
    output logic     clear_overrun
);
    localparam lb_addr_t LAST = lb_addr_t'(LINE_WORDS - 1);

    sched_state_t state;
    lb_addr_t     clr_cnt;
    logic         clr_busy;
    logic         arb_en;
    logic [1:0]   grant, ready, xfer;
    lb_wr_t [1:0] req;

    assign req[0] = '{addr: req0_addr, we: req0_we, colour: req0_colour};
    assign req[1] = '{addr: req1_addr, we: req1_we, colour: req1_colour};

    // Nothing is accepted in the line-start cycle, so no write straddles a flip.
    assign arb_en = (state == ACTIVE) && !line_start;
    assign ready  = arb_en ? grant : 2'b00;
    assign xfer   = ready & {req1_valid, req0_valid};

    assign req0_ready     = ready[0];
    assign req1_ready     = ready[1];
    assign addr_on_draw   = clr_cnt;
    assign we_on_draw     = clr_busy;
    assign clear_busy     = clr_busy;
    assign colour_on_draw = replicate(CLEAR_COLOUR);

    rr_arbiter2 u_arb (
        .clk   (clk_draw),
        .rst   (rst_draw),
        .valid ({req1_valid, req0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            state         <= IDLE;
            buffsel_draw  <= 1'b0;
            clr_cnt       <= '0;
            clr_busy      <= 1'b0;
            clear_overrun <= 1'b0;
        end else begin
            clear_overrun <= 1'b0;
            if (line_start) begin
                state         <= ACTIVE;
                buffsel_draw  <= ~buffsel_draw;
                clr_cnt       <= '0;
                clr_busy      <= 1'b1;
                // Landing on the final clear word still completes the sweep in time.
                clear_overrun <= clr_busy && (clr_cnt != LAST);
            end else if (clr_busy) begin
                if (clr_cnt == LAST) begin
                    clr_busy <= 1'b0;
                    clr_cnt  <= '0;
                end else begin
                    clr_cnt <= clr_cnt + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            addr_off_draw   <= '0;
            we_off_draw     <= '0;
            colour_off_draw <= '0;
        end else if (|xfer) begin
            addr_off_draw   <= req[xfer[1]].addr;
            we_off_draw     <= req[xfer[1]].we;
            colour_off_draw <= req[xfer[1]].colour;
        end else begin
            we_off_draw <= '0;
        end
    end
endmodule

// File: tb/tb_linebuffer_sched.sv
// Directed bench for linebuffer_sched: flip, clear sweep, arbitration, overrun, reset.
module tb_linebuffer_sched;
    import linebuffer_pkg::*;

    logic     clk_draw = 1'b0;
    logic     rst_draw;
    logic     line_start;
    logic     buffsel_draw;
    lb_addr_t addr_on_draw;
    logic     we_on_draw;
    lb_word_t colour_on_draw;
    lb_addr_t addr_off_draw;
    lb_we_t   we_off_draw;
    lb_word_t colour_off_draw;
    logic     req0_valid, req1_valid;
    lb_addr_t req0_addr, req1_addr;
    lb_we_t   req0_we, req1_we;
    lb_word_t req0_colour, req1_colour;
    logic     req0_ready, req1_ready;
    logic     clear_busy, clear_overrun;

    int checks = 0;
    int failures = 0;

    localparam lb_word_t C0    = 72'h12_3456_789A_BCDE_F012;
    localparam lb_word_t C1    = 72'hFE_DCBA_9876_5432_1098;
    localparam lb_word_t C2    = 72'hA5_5A5A_A5A5_5A5A_A5C3;
    localparam lb_word_t CLR_W = {8{9'h000}};

    linebuffer_sched #(.LINE_WORDS(80), .CLEAR_COLOUR(9'h000)) dut (
        .clk_draw(clk_draw), .rst_draw(rst_draw), .line_start(line_start),
        .buffsel_draw(buffsel_draw), .addr_on_draw(addr_on_draw), .we_on_draw(we_on_draw),
        .colour_on_draw(colour_on_draw), .addr_off_draw(addr_off_draw),
        .we_off_draw(we_off_draw), .colour_off_draw(colour_off_draw),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we),
        .req0_colour(req0_colour), .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_colour(req1_colour), .req0_ready(req0_ready),
        .req1_ready(req1_ready), .clear_busy(clear_busy), .clear_overrun(clear_overrun)
    );

    always #5 clk_draw = ~clk_draw;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk_draw);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_buffsel"}, 72'(buffsel_draw), 72'd0);
        chk({tag, "_addr_on"}, 72'(addr_on_draw), 72'd0);
        chk({tag, "_we_on"}, 72'(we_on_draw), 72'd0);
        chk({tag, "_busy"}, 72'(clear_busy), 72'd0);
        chk({tag, "_overrun"}, 72'(clear_overrun), 72'd0);
        chk({tag, "_addr_off"}, 72'(addr_off_draw), 72'd0);
        chk({tag, "_we_off"}, 72'(we_off_draw), 72'd0);
        chk({tag, "_colour_off"}, colour_off_draw, 72'd0);
        chk({tag, "_colour_on"}, colour_on_draw, CLR_W);
        chk({tag, "_ready0"}, 72'(req0_ready), 72'd0);
        chk({tag, "_ready1"}, 72'(req1_ready), 72'd0);
    endtask

    initial begin
        rst_draw = 1'b1; line_start = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_we = '0; req0_colour = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_we = '0; req1_colour = '0;
        #3;
        chk_reset_outputs("rst");
        tick();
        rst_draw = 1'b0;

        // IDLE: a valid requester is never granted before the first line start.
        req0_valid = 1'b1; req0_addr = 9'd7; req0_we = 8'hFF; req0_colour = C0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("idle_ready0", 72'(req0_ready), 72'd0);
            chk("idle_we_off", 72'(we_off_draw), 72'd0);
            chk("idle_we_on", 72'(we_on_draw), 72'd0);
            chk("idle_buffsel", 72'(buffsel_draw), 72'd0);
            tick();
        end
        req0_valid = 1'b0;

        // First line start and the full 80-word sweep.
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        chk("flip1_buffsel", 72'(buffsel_draw), 72'd1);
        for (int i = 0; i < 80; i++) begin
            #0;
            chk("sweep_we_on", 72'(we_on_draw), 72'd1);
            chk("sweep_addr", 72'(addr_on_draw), 72'(i));
            chk("sweep_busy", 72'(clear_busy), 72'd1);
            chk("sweep_overrun", 72'(clear_overrun), 72'd0);
            tick();
            #1;
        end
        chk("sweep_end_we_on", 72'(we_on_draw), 72'd0);
        chk("sweep_end_busy", 72'(clear_busy), 72'd0);

        // Both requesters valid: grants alternate starting with req0.
        tick();
        req0_valid = 1'b1; req0_addr = 9'd5; req0_we = 8'hFF; req0_colour = C0;
        req1_valid = 1'b1; req1_addr = 9'd9; req1_we = 8'hFF; req1_colour = C1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 72'(req0_ready), 72'(i % 2 == 0));
            chk("rr_ready1", 72'(req1_ready), 72'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_addr_off", 72'(addr_off_draw), (i % 2 == 1) ? 72'd5 : 72'd9);
                chk("rr_we_off", 72'(we_off_draw), 72'hFF);
                chk("rr_colour_off", colour_off_draw, (i % 2 == 1) ? C0 : C1);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rr_last_addr_off", 72'(addr_off_draw), 72'd9);
        chk("rr_last_colour_off", colour_off_draw, C1);
        tick();
        #1;
        chk("rr_idle_we_off", 72'(we_off_draw), 72'd0);

        // req0 transfer at N-1, line start at N with both requesters valid.
        req0_valid = 1'b1; req0_addr = 9'd3; req0_we = 8'h0F; req0_colour = C2;
        #1;
        chk("pre_ready0", 72'(req0_ready), 72'd1);
        tick();
        line_start = 1'b1; req1_valid = 1'b1;
        #1;
        chk("ls_ready0", 72'(req0_ready), 72'd0);
        chk("ls_ready1", 72'(req1_ready), 72'd0);
        chk("ls_addr_off", 72'(addr_off_draw), 72'd3);
        chk("ls_we_off", 72'(we_off_draw), 72'h0F);
        chk("ls_colour_off", colour_off_draw, C2);
        chk("ls_buffsel_old", 72'(buffsel_draw), 72'd1);
        tick();
        line_start = 1'b0;
        #1;
        chk("post_we_off", 72'(we_off_draw), 72'd0);
        chk("post_buffsel", 72'(buffsel_draw), 72'd0);
        chk("post_ptr_ready0", 72'(req0_ready), 72'd0);
        chk("post_ptr_ready1", 72'(req1_ready), 72'd1);
        chk("post_overrun", 72'(clear_overrun), 72'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Second sweep interrupted 40 cycles after its line start.
        for (int i = 1; i < 40; i++) tick();
        #1;
        chk("ovr_pre_addr", 72'(addr_on_draw), 72'd39);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        chk("ovr_pulse", 72'(clear_overrun), 72'd1);
        chk("ovr_addr", 72'(addr_on_draw), 72'd0);
        chk("ovr_we_on", 72'(we_on_draw), 72'd1);
        chk("ovr_buffsel", 72'(buffsel_draw), 72'd1);
        tick();
        #1;
        chk("ovr_pulse_end", 72'(clear_overrun), 72'd0);
        chk("ovr_addr1", 72'(addr_on_draw), 72'd1);

        // Line start exactly on the last clear word is not an overrun.
        for (int i = 1; i < 79; i++) tick();
        #1;
        chk("edge_addr79", 72'(addr_on_draw), 72'd79);
        chk("edge_busy", 72'(clear_busy), 72'd1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        chk("edge_no_overrun", 72'(clear_overrun), 72'd0);
        chk("edge_addr0", 72'(addr_on_draw), 72'd0);
        chk("edge_we_on", 72'(we_on_draw), 72'd1);
        chk("edge_buffsel", 72'(buffsel_draw), 72'd0);

        // Asynchronous reset mid-sweep with a requester valid.
        tick(); tick();
        req0_valid = 1'b1; req0_addr = 9'd11; req0_we = 8'hF0; req0_colour = C1;
        #1;
        rst_draw = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_draw = 1'b0;
        #1;
        chk("midrst_idle_ready0", 72'(req0_ready), 72'd0);

        // After reset the pointer is back to favouring req0.
        line_start = 1'b1;
        tick();
        line_start = 1'b0; req1_valid = 1'b1; req1_addr = 9'd2; req1_we = 8'h01;
        #1;
        chk("rst_ptr_ready0", 72'(req0_ready), 72'd1);
        chk("rst_ptr_ready1", 72'(req1_ready), 72'd0);
        tick();
        #1;
        chk("rst_ptr_addr_off", 72'(addr_off_draw), 72'd11);
        chk("rst_ptr_we_off", 72'(we_off_draw), 72'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
